mem_access_stage: RTL

- Memory-access stage. Sits between the EX_MEM latch outputs and the MEM_WB latch inputs.
- Turns a decoded load, store, LR.W or SC.W into a registered request/hit handshake with the private dcache.
- Formats load data, performs store byte-lane steering, and keeps the per-core LR/SC reservation, including snoop invalidation.
- Drives the pipeline stall and produces the dhit/result fields consumed by the MEM_WB latch.

---
 rtl/mem_access_stage.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns a decoded load/store/LR/SC into a registered dcache
// request/hit handshake, formats load data, steers store lanes and keeps the LR/SC reservation.
module mem_access_stage #(
  parameter int WORD_W   = 32,
  parameter int RESV_LSB = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              en_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        func3_i,
  input  logic [6:0]        func7_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] store_i,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [3:0]        dmembyteen,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic [WORD_W-1:0] load_o,
  output logic              dhit_o,
  output logic              stall_o,
  output logic              resv_valid_o
);

  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, DONE = 2'b10} state_t;

  state_t                   state_r, state_n;
  logic [WORD_W-1:0]        addr_r, store_r, load_r;
  logic [3:0]               byteen_r;
  logic [2:0]               f3_r;
  logic                     lr_r, sc_r, ren_r, wen_r, dhit_r;
  logic                     resv_valid_r;
  logic [WORD_W-1:RESV_LSB] resv_addr_r;

  logic       is_load_s, is_store_s, is_lr_s, is_sc_s, mem_op_s;
  logic       snoop_hit_s, resv_match_s, capture_s, sc_fail_s, req_done_s;
  logic [1:0] st_size_s;
  logic [2:0] ld_f3_s;
  logic       unused_s;

  function automatic logic [WORD_W-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [WORD_W-1:0] word);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [WORD_W-1:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{(WORD_W-8){b[7]}}, b};
      3'b001:  r = {{(WORD_W-16){h[15]}}, h};
      3'b100:  r = {{(WORD_W-8){1'b0}}, b};
      3'b101:  r = {{(WORD_W-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] steer_data(input logic [1:0] size,
                                                   input logic [WORD_W-1:0] data);
    logic [WORD_W-1:0] r;
    case (size)
      2'b00:   r = {4{data[7:0]}};
      2'b01:   r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] steer_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] r;
    case (size)
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = off[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  assign is_load_s  = (opcode_i == 7'b0000011);
  assign is_store_s = (opcode_i == 7'b0100011);
  assign is_lr_s    = (opcode_i == 7'b0101111) && (func7_i[6:2] == 5'b00010);
  assign is_sc_s    = (opcode_i == 7'b0101111) && (func7_i[6:2] == 5'b00011);
  assign mem_op_s   = valid_i & (is_load_s | is_store_s | is_lr_s | is_sc_s);
  assign st_size_s  = is_sc_s ? 2'b10 : func3_i[1:0];
  assign ld_f3_s    = is_lr_s ? 3'b010 : func3_i;
  assign unused_s   = ^{func7_i[1:0], snoop_addr[RESV_LSB-1:0]};

  // A same-cycle matching snoop already counts against an SC being captured
  assign snoop_hit_s  = snoop_inv & (snoop_addr[WORD_W-1:RESV_LSB] == resv_addr_r);
  assign resv_match_s = resv_valid_r & ~snoop_hit_s &
                        (resv_addr_r == addr_i[WORD_W-1:RESV_LSB]);
  assign req_done_s   = (state_r == REQ) & dhit;

  // Next-state and capture decode
  always_comb begin
    state_n   = state_r;
    capture_s = 1'b0;
    sc_fail_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_op_s && !flush_i) begin
          capture_s = 1'b1;
          if (is_sc_s && !resv_match_s) begin
            sc_fail_s = 1'b1;
            state_n   = DONE;
          end else begin
            state_n   = REQ;
          end
        end else begin
          state_n = IDLE;
        end
      end
      REQ: begin
        if (dhit) begin
          state_n = DONE;
        end else begin
          state_n = REQ;
        end
      end
      DONE: begin
        if (en_i || flush_i) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered completion flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      dhit_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      dhit_r  <= (state_n == DONE);
    end
  end

  // Latched request fields and result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_r   <= {WORD_W{1'b0}};
      store_r  <= {WORD_W{1'b0}};
      load_r   <= {WORD_W{1'b0}};
      byteen_r <= 4'b0000;
      f3_r     <= 3'b000;
      lr_r     <= 1'b0;
      sc_r     <= 1'b0;
      ren_r    <= 1'b0;
      wen_r    <= 1'b0;
    end else if (capture_s) begin
      addr_r   <= addr_i;
      store_r  <= steer_data(st_size_s, store_i);
      byteen_r <= steer_be(st_size_s, addr_i[1:0]);
      f3_r     <= ld_f3_s;
      lr_r     <= is_lr_s;
      sc_r     <= is_sc_s;
      ren_r    <= ~sc_fail_s & (is_load_s | is_lr_s);
      wen_r    <= ~sc_fail_s & (is_store_s | is_sc_s);
      load_r   <= sc_fail_s ? {{(WORD_W-1){1'b0}}, 1'b1} : load_r;
    end else if (req_done_s) begin
      ren_r    <= 1'b0;
      wen_r    <= 1'b0;
      // Writes (stores and successful SC) report zero
      load_r   <= ren_r ? fmt_load(f3_r, addr_r[1:0], dmemload) : {WORD_W{1'b0}};
    end
  end

  // Reservation: a completing LR wins over a coincident snoop
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resv_valid_r <= 1'b0;
      resv_addr_r  <= {(WORD_W-RESV_LSB){1'b0}};
    end else if (req_done_s && lr_r) begin
      resv_valid_r <= 1'b1;
      resv_addr_r  <= addr_r[WORD_W-1:RESV_LSB];
    end else if (sc_fail_s || (req_done_s && sc_r) || snoop_hit_s) begin
      resv_valid_r <= 1'b0;
    end
  end

  assign dmemREN      = ren_r;
  assign dmemWEN      = wen_r;
  assign dmemaddr     = {addr_r[WORD_W-1:2], 2'b00};
  assign dmemstore    = store_r;
  assign dmembyteen   = byteen_r;
  assign load_o       = load_r;
  assign dhit_o       = dhit_r;
  assign resv_valid_o = resv_valid_r;
  assign stall_o      = ~RST & (((state_r == IDLE) & mem_op_s & ~flush_i) | (state_r == REQ));

endmodule
